cvita_hdr_framer: RTL and testbench

CVITA_HDR_FRAMER -- requirements
Module: cvita_hdr_framer

---
 rtl/cvita_hdr_framer_pkg.sv | 59 +++++
 rtl/cvita_hdr_framer_if.sv | 19 +
 rtl/axi_fifo_flop2.sv | 57 +++++
 rtl/cvita_hdr_framer.sv | 154 +++++++++++++++
 tb/tb_cvita_hdr_framer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cvita_hdr_framer_pkg.sv
// ----------------------------------------------------------------------------
// cvita_hdr_framer_pkg : shared types, CVITA header field layout and helpers
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package cvita_hdr_framer_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_TIME = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    localparam int HDR_TYPE_LSB     = 62;
    localparam int HDR_HAS_TIME_BIT = 61;
    localparam int HDR_EOB_BIT      = 60;
    localparam int HDR_SEQ_LSB      = 48;
    localparam int HDR_LEN_LSB      = 32;
    localparam int HDR_SRC_LSB      = 16;
    localparam int HDR_DST_LSB      = 0;

    localparam int CVITA_HDR_BYTES  = 8;
    localparam int CVITA_TIME_BYTES = 8;

    localparam logic [1:0] PKT_TYPE_DATA = 2'd0;
    localparam logic [1:0] PKT_TYPE_FC   = 2'd1;
    localparam logic [1:0] PKT_TYPE_CMD  = 2'd2;
    localparam logic [1:0] PKT_TYPE_RESP = 2'd3;

    // Length field counts header (+ timestamp) bytes; wraps modulo 2^16.
    function automatic logic [15:0] pkt_length(input logic [15:0] payload_bytes,
                                               input logic        time_flag);
        return payload_bytes + (time_flag ? 16'(CVITA_HDR_BYTES + CVITA_TIME_BYTES)
                                          : 16'(CVITA_HDR_BYTES));
    endfunction

    function automatic logic [63:0] make_header(input logic [1:0]  ptype,
                                                input logic        time_flag,
                                                input logic        eob_flag,
                                                input logic [11:0] seq,
                                                input logic [15:0] len,
                                                input logic [15:0] src,
                                                input logic [15:0] dst);
        logic [63:0] hdr;
        hdr                    = '0;
        hdr[HDR_TYPE_LSB +: 2] = ptype;
        hdr[HDR_HAS_TIME_BIT]  = time_flag;
        hdr[HDR_EOB_BIT]       = eob_flag;
        hdr[HDR_SEQ_LSB +: 12] = seq;
        hdr[HDR_LEN_LSB +: 16] = len;
        hdr[HDR_SRC_LSB +: 16] = src;
        hdr[HDR_DST_LSB +: 16] = dst;
        return hdr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cvita_hdr_framer_if.sv
// ----------------------------------------------------------------------------
// cvita_hdr_framer_if : AXI-stream bundle (tdata/tlast/tvalid/tready)
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface cvita_hdr_framer_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/axi_fifo_flop2.sv
// ----------------------------------------------------------------------------
// axi_fifo_flop2 : two-entry skid register; registered tready, full throughput
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module axi_fifo_flop2 #(
    parameter int WIDTH = 65
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] i_tdata,
    input  wire logic             i_tvalid,
    output logic                  i_tready,
    output logic      [WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  wire logic             o_tready
);

    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             valid0;
    logic             valid1;

    assign i_tready = ~valid1;
    assign o_tdata  = data0;
    assign o_tvalid = valid0;

    // data0 is the presented slot; data1 only fills when data0 is stalled.
    always_ff @(posedge clk) begin
        if (reset | clear) begin
            data0  <= '0;
            data1  <= '0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
        end else if (valid1) begin
            if (o_tready) begin
                data0  <= data1;
                valid1 <= 1'b0;
            end
        end else if (i_tvalid) begin
            if (!valid0 || o_tready) begin
                data0  <= i_tdata;
                valid0 <= 1'b1;
            end else begin
                data1  <= i_tdata;
                valid1 <= 1'b1;
            end
        end else if (o_tready) begin
            valid0 <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cvita_hdr_framer.sv
// ----------------------------------------------------------------------------
// cvita_hdr_framer : prepends CVITA header (and optional timestamp) to payload
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cvita_hdr_framer
    import cvita_hdr_framer_pkg::*;
#(
    parameter int REGISTER      = 1,
    parameter int USE_SEQNUM_IN = 0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        clear,
    input  wire logic [1:0]  pkt_type,
    input  wire logic        eob,
    input  wire logic        has_time,
    input  wire logic [11:0] seqnum,
    input  wire logic [15:0] payload_length,
    input  wire logic [15:0] src_sid,
    input  wire logic [15:0] dst_sid,
    input  wire logic [63:0] vita_time,
    cvita_hdr_framer_if.slave  payload,
    cvita_hdr_framer_if.master framed,
    output logic             hdr_stb
);

    logic        rst_any;
    state_t      state;
    logic [63:0] time_reg;
    logic [11:0] seq_used;
    logic [63:0] header;

    logic [63:0] int_tdata;
    logic        int_tlast;
    logic        int_tvalid;
    logic        int_tready;
    logic        body_last_hs;

    assign rst_any      = reset | clear;
    assign header       = make_header(pkt_type, has_time, eob, seq_used,
                                      pkt_length(payload_length, has_time),
                                      src_sid, dst_sid);
    assign hdr_stb      = (state == ST_HDR) & int_tvalid & int_tready;
    assign body_last_hs = (state == ST_BODY) & int_tvalid & int_tready & int_tlast;

    // Internal stream is gated during reset so the combinational variant
    // also shows an idle, all-zero output while reset/clear is high.
    always_comb begin
        int_tvalid     = 1'b0;
        int_tlast      = 1'b0;
        int_tdata      = '0;
        payload.tready = 1'b0;
        if (!rst_any) begin
            case (state)
                ST_HDR: begin
                    int_tvalid = payload.tvalid;
                    int_tdata  = header;
                end
                ST_TIME: begin
                    int_tvalid = 1'b1;
                    int_tdata  = time_reg;
                end
                ST_BODY: begin
                    int_tvalid     = payload.tvalid;
                    int_tlast      = payload.tlast;
                    int_tdata      = payload.tdata;
                    payload.tready = int_tready;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_any) begin
            state    <= ST_HDR;
            time_reg <= '0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (int_tvalid && int_tready) begin
                        time_reg <= vita_time;
                        state    <= has_time ? ST_TIME : ST_BODY;
                    end
                end
                ST_TIME: begin
                    if (int_tready) begin
                        state <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (body_last_hs) begin
                        state <= ST_HDR;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

    generate
        if (USE_SEQNUM_IN != 0) begin : g_seq_in
            logic unused_last_hs;
            assign unused_last_hs = body_last_hs;
            assign seq_used       = seqnum;
        end else begin : g_seq_cnt
            logic [11:0] seq_cnt;
            logic        unused_seqnum;
            assign unused_seqnum = ^seqnum;
            assign seq_used      = seq_cnt;

            always_ff @(posedge clk) begin
                if (rst_any) begin
                    seq_cnt <= '0;
                end else if (body_last_hs) begin
                    seq_cnt <= seq_cnt + 12'd1;
                end
            end
        end
    endgenerate

    generate
        if (REGISTER != 0) begin : g_out_reg
            logic [64:0] flop_out;

            axi_fifo_flop2 #(
                .WIDTH (65)
            ) u_out_flop (
                .clk      (clk),
                .reset    (reset),
                .clear    (clear),
                .i_tdata  ({int_tlast, int_tdata}),
                .i_tvalid (int_tvalid),
                .i_tready (int_tready),
                .o_tdata  (flop_out),
                .o_tvalid (framed.tvalid),
                .o_tready (framed.tready)
            );

            assign framed.tlast = flop_out[64];
            assign framed.tdata = flop_out[63:0];
        end else begin : g_out_comb
            assign framed.tdata  = int_tdata;
            assign framed.tlast  = int_tlast;
            assign framed.tvalid = int_tvalid;
            assign int_tready    = framed.tready;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cvita_hdr_framer.sv
// ----------------------------------------------------------------------------
// tb_cvita_hdr_framer : directed + randomized check against a packet-level model
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cvita_hdr_framer;
    import cvita_hdr_framer_pkg::*;

    localparam int HS_BUDGET    = 200;
    localparam int DRAIN_BUDGET = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clear;
    logic [1:0]  pkt_type;
    logic        eob;
    logic        has_time;
    logic [11:0] seqnum;
    logic [15:0] payload_length;
    logic [15:0] src_sid;
    logic [15:0] dst_sid;
    logic [63:0] vita_time;
    logic        hdr_stb_a;
    logic        hdr_stb_b;

    cvita_hdr_framer_if pay_a ();
    cvita_hdr_framer_if frm_a ();
    cvita_hdr_framer_if pay_b ();
    cvita_hdr_framer_if frm_b ();

    // The combinational instance mirrors the registered one's payload input.
    assign pay_b.tdata  = pay_a.tdata;
    assign pay_b.tlast  = pay_a.tlast;
    assign pay_b.tvalid = pay_a.tvalid;
    assign frm_b.tready = 1'b1;

    cvita_hdr_framer #(.REGISTER(1), .USE_SEQNUM_IN(0)) u_dut_reg (
        .clk(clk), .reset(reset), .clear(clear),
        .pkt_type(pkt_type), .eob(eob), .has_time(has_time), .seqnum(seqnum),
        .payload_length(payload_length), .src_sid(src_sid), .dst_sid(dst_sid),
        .vita_time(vita_time), .payload(pay_a), .framed(frm_a), .hdr_stb(hdr_stb_a)
    );

    cvita_hdr_framer #(.REGISTER(0), .USE_SEQNUM_IN(0)) u_dut_comb (
        .clk(clk), .reset(reset), .clear(clear),
        .pkt_type(pkt_type), .eob(eob), .has_time(has_time), .seqnum(seqnum),
        .payload_length(payload_length), .src_sid(src_sid), .dst_sid(dst_sid),
        .vita_time(vita_time), .payload(pay_b), .framed(frm_b), .hdr_stb(hdr_stb_b)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          seq_model = 0;
    int          hdr_cnt = 0;
    bit          rand_ready = 1'b0;
    bit          b_mon = 1'b0;
    bit          stall_prev = 1'b0;
    logic [64:0] held;
    logic [64:0] exp_q[$];
    logic [64:0] got_a[$];
    logic [64:0] got_b[$];
    int          cyc_a[$];
    int          cyc_b[$];

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Header built from field meanings with plain integer arithmetic.
    function automatic logic [63:0] ref_header(input int seq);
        logic [63:0] len;
        len = (64'(payload_length) + (has_time ? 64'd16 : 64'd8)) % 64'd65536;
        return (64'(pkt_type) << 62) + (64'(has_time) << 61) + (64'(eob) << 60)
             + (64'(seq) << 48) + (len << 32) + (64'(src_sid) << 16) + 64'(dst_sid);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rand_ready = rand_ready;
        frm_a.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        #2;
        if (stall_prev && !reset) begin
            check("stall_valid", 65'(frm_a.tvalid), 65'(1));
            check("stall_data", {frm_a.tlast, frm_a.tdata}, held);
        end
        stall_prev = frm_a.tvalid && !frm_a.tready && !reset;
        held       = {frm_a.tlast, frm_a.tdata};
        if (frm_a.tvalid && frm_a.tready) begin
            got_a.push_back({frm_a.tlast, frm_a.tdata});
            cyc_a.push_back(cyc);
        end
        if (hdr_stb_a) hdr_cnt++;
        if (b_mon && frm_b.tvalid) begin
            got_b.push_back({frm_b.tlast, frm_b.tdata});
            cyc_b.push_back(cyc);
        end
    end

    task automatic rand_fields(input bit ht);
        pkt_type       = 2'($urandom_range(0, 3));
        eob            = 1'($urandom_range(0, 1));
        has_time       = ht;
        seqnum         = 12'($urandom);
        payload_length = 16'($urandom);
        src_sid        = 16'($urandom);
        dst_sid        = 16'($urandom);
        vita_time      = {$urandom, $urandom};
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic l, input int idle_pct,
                              output bit ok);
        int waited = 0;
        ok = 1'b1;
        @(negedge clk);
        while ($urandom_range(0, 99) < idle_pct) begin
            pay_a.tvalid = 1'b0;
            @(negedge clk);
        end
        pay_a.tdata  = d;
        pay_a.tlast  = l;
        pay_a.tvalid = 1'b1;
        #1;
        while (pay_a.tready !== 1'b1) begin
            if (waited == HS_BUDGET) begin
                check("handshake_wait", 65'(pay_a.tready), 65'(1));
                pay_a.tvalid = 1'b0;
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        @(posedge clk);
        #1;
        pay_a.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nbeats, input int idle_pct, output bit ok);
        logic [63:0] pl[$];
        ok = 1'b1;
        for (int i = 0; i < nbeats; i++) pl.push_back({$urandom, $urandom});
        exp_q.push_back({1'b0, ref_header(seq_model)});
        if (has_time) exp_q.push_back({1'b0, vita_time});
        for (int i = 0; i < nbeats; i++) exp_q.push_back({(i == nbeats - 1), pl[i]});
        seq_model = (seq_model + 1) % 4096;
        for (int i = 0; i < nbeats; i++) begin
            drive_beat(pl[i], (i == nbeats - 1), idle_pct, ok);
            if (!ok) return;
        end
    endtask

    task automatic wait_out(input int n);
        int w = 0;
        while (got_a.size() < n && w < DRAIN_BUDGET) begin
            @(posedge clk);
            w++;
        end
        repeat (8) @(posedge clk);
        check("drain_count", 65'(got_a.size()), 65'(n));
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < got_a.size()) ? got_a[i] : 65'bx, exp_q[i]);
        exp_q.delete();
        got_a.delete();
        cyc_a.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seq_model = 0;
        exp_q.delete();
        got_a.delete();
        cyc_a.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int npkts;
        reset = 1'b1;
        clear = 1'b0;
        rand_fields(1'b0);
        pay_a.tdata  = 64'hDEAD_BEEF_0123_4567;
        pay_a.tlast  = 1'b0;
        pay_a.tvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_otvalid_reg",  65'(frm_a.tvalid), 65'(0));
        check("rst_otlast_reg",   65'(frm_a.tlast),  65'(0));
        check("rst_otdata_reg",   65'(frm_a.tdata),  65'(0));
        check("rst_itready_reg",  65'(pay_a.tready), 65'(0));
        check("rst_hdrstb_reg",   65'(hdr_stb_a),    65'(0));
        check("rst_otvalid_comb", 65'(frm_b.tvalid), 65'(0));
        check("rst_otdata_comb",  65'(frm_b.tdata),  65'(0));
        check("rst_itready_comb", 65'(pay_b.tready), 65'(0));
        check("rst_hdrstb_comb",  65'(hdr_stb_b),    65'(0));
        pay_a.tvalid = 1'b0;
        reset = 1'b0;
        b_mon = 1'b1;

        // Single packet without time, then with time; both instances compared.
        pkt_type = PKT_TYPE_DATA; eob = 1'b0; has_time = 1'b0; seqnum = 12'hABC;
        payload_length = 16'd24; src_sid = 16'h0010; dst_sid = 16'h0020;
        send_pkt(3, 0, ok);
        has_time = 1'b1; payload_length = 16'd16; vita_time = 64'h1122334455667788;
        send_pkt(2, 0, ok);
        wait_out(8);
        check("t029_header", got_a[0], {1'b0, 64'h0000_0020_0010_0020});
        check("t029_last",   65'(got_a[3][64]), 65'(1));
        check("t029_nolast", 65'(got_a[2][64]), 65'(0));
        check("t030_hastime", 65'(got_a[4][61]), 65'(1));
        check("t030_length",  65'(got_a[4][47:32]), 65'(32));
        check("t030_time",    got_a[5], {1'b0, 64'h1122334455667788});
        check("t030_last",    65'(got_a[7][64]), 65'(1));
        check("comb_count", 65'(got_b.size()), 65'(got_a.size()));
        for (int i = 0; i < 8; i++) begin
            check("reg_vs_comb", got_b[i], got_a[i]);
            check("latency_diff", 65'(cyc_a[i] - cyc_b[i]), 65'(1));
        end
        compare_all("directed_beat");
        b_mon = 1'b0;

        // Random stalls on both sides over many packets.
        rand_ready = 1'b1;
        hdr_cnt = 0;
        npkts = 0;
        for (int p = 0; p < 1000; p++) begin
            rand_fields(1'($urandom_range(0, 1)));
            send_pkt(int'($urandom_range(1, 6)), 50, ok);
            npkts++;
            if (!ok) break;
        end
        wait_out(exp_q.size());
        compare_all("random_beat");
        check("hdr_stb_count", 65'(hdr_cnt), 65'(npkts));

        // Reset on the second payload beat of a five-beat packet.
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        rand_fields(1'b0);
        drive_beat({$urandom, $urandom}, 1'b0, 0, ok);
        @(negedge clk);
        pay_a.tdata  = {$urandom, $urandom};
        pay_a.tlast  = 1'b0;
        pay_a.tvalid = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        pay_a.tvalid = 1'b0;
        check("midrst_otvalid", 65'(frm_a.tvalid), 65'(0));
        check("midrst_itready", 65'(pay_a.tready), 65'(0));
        exp_q.delete();
        got_a.delete();
        cyc_a.delete();
        seq_model = 0;
        rand_fields(1'b1);
        send_pkt(4, 0, ok);
        wait_out(exp_q.size());
        check("midrst_seq0", 65'(got_a[0][59:48]), 65'(0));
        compare_all("post_reset_beat");

        // Sequence counter wrap with back-to-back single-beat packets.
        pulse_reset();
        for (int p = 0; p < 4097; p++) begin
            rand_fields(1'b0);
            send_pkt(1, 0, ok);
            if (!ok) break;
        end
        wait_out(8194);
        check("wrap_seq4095", 65'(got_a[8190][59:48]), 65'(4095));
        check("wrap_seq0",    65'(got_a[8192][59:48]), 65'(0));
        compare_all("wrap_beat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
